// File: rtl/board_status_pkg.sv
// Shared types and constants for the board reset sequencer / status block.
// state_t : FSM state with fixed 3-bit encodings exported on the state port.
// LED_*   : bit positions within the status LED bus.
// cnt_w   : counter width able to hold 0..limit-1 (at least one bit).
package board_status_pkg;

    typedef enum logic [2:0] {
        ST_HOLD      = 3'd0,
        ST_WAIT_PCIE = 3'd1,
        ST_WAIT_CAL  = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    localparam int unsigned LED_HB    = 0;
    localparam int unsigned LED_PCIE  = 1;
    localparam int unsigned LED_CAL   = 2;
    localparam int unsigned LED_FAULT = 3;
    localparam int unsigned LED_BANK0 = 4;

    function automatic int unsigned cnt_w(input int unsigned limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/board_status_seq_sync.sv
// Multi-stage flop synchroniser for a vector of asynchronous inputs.
// clk   : destination clock
// rst_n : asynchronous active-low reset, clears all stages to 0
// d     : asynchronous input vector
// q     : synchronised output (last stage)
module sync_bits #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stg [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(STAGES); i++) stg[i] <= '0;
        end else begin
            stg[0] <= d;
            for (int i = 1; i < int'(STAGES); i++) stg[i] <= stg[i-1];
        end
    end

    assign q = stg[STAGES-1];

endmodule

// File: rtl/board_status_seq.sv
// Board reset sequencer and status indicator.
// Holds the global reset for a fixed time, releases it once PCIe npor is up,
// releases the kernel once every enabled memory bank has calibrated, and
// flags a sticky fault on calibration failure, timeout or loss of calibration.
// Ports:
//   config_clk      : sole clock
//   resetn          : async active-low reset (deassertion synchronised here)
//   pcie_npor       : PCIe npor_out_reset_n (async)
//   mem_cal_success : per-bank calibration success (async)
//   mem_cal_fail    : per-bank calibration failure (async)
//   mem_enable      : per-bank enable mask, 0 = bank ignored
//   sys_resetn      : global reset release
//   kernel_resetn   : kernel reset release
//   cal_done        : all enabled banks calibrated (in RUN)
//   fault           : sticky fault flag
//   state           : current FSM state encoding
//   leds            : registered status LEDs
module board_status_seq
    import board_status_pkg::*;
#(
    parameter int unsigned NUM_MEM     = 2,
    parameter int unsigned LED_W       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned HOLD_CYCLES = 1024,
    parameter int unsigned CAL_TIMEOUT = 50_000_000,
    parameter int unsigned HB_DIV      = 25_000_000
) (
    input  logic               config_clk,
    input  logic               resetn,
    input  logic               pcie_npor,
    input  logic [NUM_MEM-1:0] mem_cal_success,
    input  logic [NUM_MEM-1:0] mem_cal_fail,
    input  logic [NUM_MEM-1:0] mem_enable,
    output logic               sys_resetn,
    output logic               kernel_resetn,
    output logic               cal_done,
    output logic               fault,
    output logic [2:0]         state,
    output logic [LED_W-1:0]   leds
);

    localparam int unsigned HW = cnt_w(HOLD_CYCLES);
    localparam int unsigned TW = cnt_w(CAL_TIMEOUT);
    localparam int unsigned BW = cnt_w(HB_DIV);
    localparam int unsigned SW = 1 + 2 * NUM_MEM;
    localparam int unsigned NB = (NUM_MEM < LED_W - 4) ? NUM_MEM : LED_W - 4;

    // Reset synchroniser: async assert, deassert after SYNC_STAGES edges
    logic [SYNC_STAGES-1:0] rst_sync;
    logic                   rst_n;

    always_ff @(posedge config_clk or negedge resetn) begin
        if (!resetn) rst_sync <= '0;
        else         rst_sync <= {rst_sync[SYNC_STAGES-2:0], 1'b1};
    end

    assign rst_n = rst_sync[SYNC_STAGES-1];

    // Input synchroniser for {npor, success, fail}
    logic [SW-1:0]      raw;
    logic [SW-1:0]      syn;
    logic               npor_s;
    logic [NUM_MEM-1:0] succ_s;
    logic [NUM_MEM-1:0] fail_s;

    assign raw = {pcie_npor, mem_cal_success, mem_cal_fail};

    sync_bits #(.WIDTH(SW), .STAGES(SYNC_STAGES)) u_sync (
        .clk   (config_clk),
        .rst_n (rst_n),
        .d     (raw),
        .q     (syn)
    );

    assign npor_s = syn[SW-1];
    assign succ_s = syn[2*NUM_MEM-1 -: NUM_MEM];
    assign fail_s = syn[NUM_MEM-1:0];

    // Disabled banks count as calibrated and can never fail
    logic ok_c;
    logic bad_c;

    assign ok_c  = &(succ_s | ~mem_enable);
    assign bad_c = |(fail_s & mem_enable);

    state_t          st_q;
    state_t          nxt_c;
    logic [HW-1:0]   hold_cnt;
    logic [TW-1:0]   timer;
    logic [BW-1:0]   hb_cnt;
    logic            hb_wrap_c;
    logic [LED_W-1:0] led_c;

    // Next-state function; npor loss overrides everything past WAIT_PCIE
    always_comb begin
        nxt_c = st_q;
        case (st_q)
            ST_HOLD:      if (hold_cnt == HW'(HOLD_CYCLES - 1)) nxt_c = ST_WAIT_PCIE;
            ST_WAIT_PCIE: if (npor_s) nxt_c = ST_WAIT_CAL;
            ST_WAIT_CAL: begin
                if (bad_c)                               nxt_c = ST_FAULT;
                else if (ok_c)                           nxt_c = ST_RUN;
                else if (timer == TW'(CAL_TIMEOUT - 1))  nxt_c = ST_FAULT;
            end
            ST_RUN:       if (!ok_c || bad_c) nxt_c = ST_FAULT;
            ST_FAULT:     nxt_c = ST_FAULT;
            default:      nxt_c = ST_HOLD;
        endcase
        if (!npor_s && (st_q == ST_WAIT_CAL || st_q == ST_RUN || st_q == ST_FAULT))
            nxt_c = ST_HOLD;
    end

    assign hb_wrap_c = (hb_cnt == BW'(HB_DIV - 1));

    // LED image reflecting the state being entered on this edge
    always_comb begin
        led_c            = '0;
        led_c[LED_HB]    = leds[LED_HB] ^ hb_wrap_c;
        led_c[LED_PCIE]  = npor_s;
        led_c[LED_CAL]   = (nxt_c == ST_RUN);
        led_c[LED_FAULT] = (nxt_c == ST_FAULT);
        for (int i = 0; i < int'(NB); i++)
            led_c[LED_BANK0 + i] = succ_s[i] & mem_enable[i];
    end

    // State, counters and registered outputs
    always_ff @(posedge config_clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q          <= ST_HOLD;
            hold_cnt      <= '0;
            timer         <= '0;
            hb_cnt        <= '0;
            sys_resetn    <= 1'b0;
            kernel_resetn <= 1'b0;
            cal_done      <= 1'b0;
            fault         <= 1'b0;
            leds          <= '0;
        end else begin
            st_q <= nxt_c;

            // Hold counter restarts from 0 on every entry to HOLD
            if (st_q == ST_HOLD && nxt_c == ST_HOLD) hold_cnt <= hold_cnt + HW'(1);
            else                                     hold_cnt <= '0;

            // Timeout timer only advances in WAIT_CAL and saturates at its limit
            if (st_q == ST_WAIT_PCIE && nxt_c == ST_WAIT_CAL)
                timer <= '0;
            else if (st_q == ST_WAIT_CAL && timer != TW'(CAL_TIMEOUT - 1))
                timer <= timer + TW'(1);

            if (hb_wrap_c) hb_cnt <= '0;
            else           hb_cnt <= hb_cnt + BW'(1);

            sys_resetn    <= (nxt_c != ST_HOLD);
            kernel_resetn <= (nxt_c == ST_RUN);
            cal_done      <= (nxt_c == ST_RUN);
            fault         <= (nxt_c == ST_FAULT);
            leds          <= led_c;
        end
    end

    assign state = st_q;

endmodule

// File: tb/tb_board_status_seq.sv
// Self-checking bench for board_status_seq: directed bring-up / fault / re-reset
// scenarios with hand-derived expectations, then randomized stimulus, all
// compared every cycle against a timestamp-based behavioural model.
module tb_board_status_seq;

    localparam int unsigned NM = 2;
    localparam int unsigned LW = 8;
    localparam int unsigned SS = 2;
    localparam int unsigned HC = 16;
    localparam int unsigned CT = 100;
    localparam int unsigned HB = 8;

    logic          clk    = 1'b0;
    logic          resetn = 1'b0;
    logic          npor   = 1'b0;
    logic [NM-1:0] succ   = '0;
    logic [NM-1:0] fail   = '0;
    logic [NM-1:0] en     = 2'b11;

    logic          sys_resetn;
    logic          kernel_resetn;
    logic          cal_done;
    logic          fault;
    logic [2:0]    state;
    logic [LW-1:0] leds;

    board_status_seq #(
        .NUM_MEM(NM), .LED_W(LW), .SYNC_STAGES(SS),
        .HOLD_CYCLES(HC), .CAL_TIMEOUT(CT), .HB_DIV(HB)
    ) dut (
        .config_clk      (clk),
        .resetn          (resetn),
        .pcie_npor       (npor),
        .mem_cal_success (succ),
        .mem_cal_fail    (fail),
        .mem_enable      (en),
        .sys_resetn      (sys_resetn),
        .kernel_resetn   (kernel_resetn),
        .cal_done        (cal_done),
        .fault           (fault),
        .state           (state),
        .leds            (leds)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int e        = 0;
    bit cmp_en   = 0;

    // Model state: spec state codes, edge index, and timestamps of HOLD / WAIT_CAL entry
    int            m_rs;
    int            m_state;
    int            m_n;
    int            hold_start;
    int            cal_start;
    logic [4:0]    dq[$];
    logic          e_sys, e_ker, e_cal, e_fault;
    logic [2:0]    e_state;
    logic [LW-1:0] e_leds;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_tick();
        logic [4:0]    s;
        logic          np, ok, bad;
        logic [NM-1:0] sc, fl;
        int            ns;
        if (!resetn) begin
            m_rs = 0; m_state = 0; m_n = 0; hold_start = 0; cal_start = 0;
            dq.delete();
            repeat (SS) dq.push_back(5'b0);
            e_sys = 0; e_ker = 0; e_cal = 0; e_fault = 0; e_state = 0; e_leds = '0;
        end else if (m_rs < int'(SS)) begin
            m_rs++;
        end else begin
            s  = dq.pop_front();
            dq.push_back({npor, succ, fail});
            np = s[4]; sc = s[3:2]; fl = s[1:0];
            ok  = &(sc | ~en);
            bad = |(fl & en);
            ns  = m_state;
            case (m_state)
                0: if (m_n - hold_start == int'(HC) - 1) ns = 1;
                1: if (np) ns = 2;
                2: if (bad) ns = 4; else if (ok) ns = 3;
                   else if (m_n - cal_start == int'(CT) - 1) ns = 4;
                3: if (!ok || bad) ns = 4;
                default: ns = m_state;
            endcase
            if (m_state >= 2 && !np) ns = 0;
            if (ns == 0 && m_state != 0) hold_start = m_n + 1;
            if (ns == 2 && m_state == 1) cal_start = m_n + 1;
            e_sys   = (ns != 0);
            e_ker   = (ns == 3);
            e_cal   = (ns == 3);
            e_fault = (ns == 4);
            e_state = 3'(ns);
            e_leds  = '0;
            e_leds[0]   = 1'(((m_n + 1) / int'(HB)) % 2);
            e_leds[1]   = np;
            e_leds[2]   = (ns == 3);
            e_leds[3]   = (ns == 4);
            e_leds[5:4] = sc & en;
            m_state = ns;
            m_n++;
        end
    endtask

    task automatic compare_all();
        check("state",         32'(state),         32'(e_state));
        check("sys_resetn",    32'(sys_resetn),    32'(e_sys));
        check("kernel_resetn", 32'(kernel_resetn), 32'(e_ker));
        check("cal_done",      32'(cal_done),      32'(e_cal));
        check("fault",         32'(fault),         32'(e_fault));
        check("leds",          32'(leds),          32'(e_leds));
    endtask

    task automatic step();
        @(posedge clk);
        #2;
        e++;
    endtask

    task automatic wait_st(input logic [2:0] st, input int budget, input string name);
        int k = 0;
        while (state !== st && k < budget) begin
            step();
            k++;
        end
        check(name, 32'(state), 32'(st));
    endtask

    task automatic npor_pulse();
        npor = 1'b0;
        step();
        npor = 1'b1;
    endtask

    initial begin
        int  k;
        bit  saw_run;
        logic h;
        int  low_left;
        int  rst_left;

        fork
            forever begin
                @(posedge clk or negedge resetn);
                model_tick();
            end
            forever begin
                @(negedge clk);
                if (cmp_en) compare_all();
            end
        join_none

        repeat (3) @(posedge clk);
        #2;
        cmp_en = 1;
        check("reset_state", 32'(state), 32'd0);
        check("reset_outputs", 32'({sys_resetn, kernel_resetn, cal_done, fault, leds}), 32'd0);

        // Nominal bring-up; the 2-flop reset synchroniser precedes the 16-cycle hold
        resetn = 1'b1;
        e = 0;
        while (!sys_resetn && e < 100) step();
        check("sys_resetn_rise_edge", 32'(e), 32'(SS + HC));
        while (e < 20) step();
        npor = 1'b1;
        while (state !== 3'd2 && e < 100) step();
        check("wait_cal_entry_edge", 32'(e), 32'd23);
        while (e < 40) step();
        succ = 2'b11;
        while (state !== 3'd3 && e < 100) step();
        check("run_entry_edge", 32'(e), 32'd43);
        check("run_kernel_resetn", 32'(kernel_resetn), 32'd1);
        check("run_bank_leds", 32'(leds[5:4]), 32'd3);
        check("run_cal_led", 32'(leds[2]), 32'd1);

        // Heartbeat half-period
        h = leds[0]; k = 0;
        while (leds[0] === h && k < 50) begin step(); k++; end
        h = leds[0]; k = 0;
        while (leds[0] === h && k < 50) begin step(); k++; end
        check("heartbeat_half_period", 32'(k), 32'(HB));

        // Host re-reset from RUN
        npor = 1'b0; step(); npor = 1'b1; k = 1;
        while (state !== 3'd0 && k < 20) begin step(); k++; end
        check("rerun_hold_latency", 32'(k), 32'd3);
        check("rerun_sys_resetn_low", 32'(sys_resetn), 32'd0);
        k = 0;
        while (!sys_resetn && k < 50) begin step(); k++; end
        check("rerun_hold_length", 32'(k), 32'(HC));
        wait_st(3'd3, 20, "rerun_back_to_run");

        // Calibration timeout with bank 1 never calibrating
        succ = 2'b01;
        npor_pulse();
        wait_st(3'd2, 60, "timeout_wait_cal");
        k = 0;
        while (state === 3'd2 && k < 200) begin step(); k++; end
        check("timeout_cycles", 32'(k), 32'(CT));
        check("timeout_state", 32'(state), 32'd4);
        check("timeout_fault_led", 32'(leds[3]), 32'd1);
        check("timeout_kernel_resetn", 32'(kernel_resetn), 32'd0);

        // Re-reset from FAULT, then bring up with bank 1 masked
        en = 2'b01; succ = 2'b01;
        npor = 1'b0; step(); npor = 1'b1; k = 1;
        while (state !== 3'd0 && k < 20) begin step(); k++; end
        check("fault_rereset_latency", 32'(k), 32'd3);
        check("fault_cleared", 32'(fault), 32'd0);
        wait_st(3'd3, 60, "masked_run");
        check("masked_no_fault", 32'(fault), 32'd0);
        check("masked_bank1_led", 32'(leds[5]), 32'd0);
        check("masked_bank0_led", 32'(leds[4]), 32'd1);

        // Fail and success arriving together in WAIT_CAL must fault
        en = 2'b11; succ = 2'b00;
        npor_pulse();
        wait_st(3'd2, 60, "prio_wait_cal");
        succ = 2'b11; fail = 2'b10;
        saw_run = 0;
        repeat (8) begin
            step();
            if (state === 3'd3) saw_run = 1;
        end
        check("prio_never_run", 32'(saw_run), 32'd0);
        check("prio_fault", 32'(state), 32'd4);
        fail = 2'b00;
        npor_pulse();
        wait_st(3'd3, 60, "prio_recover_run");

        // Asynchronous reset mid-RUN
        step();
        resetn = 1'b0;
        #1;
        check("async_rst_state", 32'(state), 32'd0);
        check("async_rst_outputs", 32'({sys_resetn, kernel_resetn, cal_done, fault, leds}), 32'd0);
        repeat (3) step();
        resetn = 1'b1;

        // Randomized traffic
        low_left = 0;
        rst_left = 0;
        for (int c = 0; c < 4000; c++) begin
            if (low_left > 0) begin
                low_left--;
                if (low_left == 0) npor = 1'b1;
            end else if ($urandom_range(0, 999) < 15) begin
                npor = 1'b0;
                low_left = int'($urandom_range(1, 4));
            end
            for (int b = 0; b < int'(NM); b++)
                if ($urandom_range(0, 99) < 3) succ[b] = ($urandom_range(0, 3) != 0);
            if (fail != 0) begin
                if ($urandom_range(0, 9) == 0) fail = '0;
            end else if ($urandom_range(0, 999) < 4) begin
                fail[$urandom_range(0, 1)] = 1'b1;
            end
            if ($urandom_range(0, 999) < 5) en = 2'($urandom_range(0, 3));
            if (rst_left > 0) begin
                rst_left--;
                if (rst_left == 0) resetn = 1'b1;
            end else if ($urandom_range(0, 999) < 2) begin
                resetn = 1'b0;
                rst_left = int'($urandom_range(1, 3));
            end
            step();
        end
        resetn = 1'b1;
        repeat (4) step();

        cmp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
